// File: rtl/pulse_meter_pkg.sv
// rtl/pulse_meter_pkg.sv - shared state encoding and turnaround timing for the pulse meter
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        FIRE,
        HOLDOFF
    } state_t;

    localparam int DEF_MIN_WIDTH      = 4;
    localparam int DEF_DELAY_CYCLES   = 100;
    localparam int DEF_PULSE_CYCLES   = 10;
    localparam int DEF_HOLDOFF_CYCLES = 50;
    localparam int DEF_CNT_W          = 16;

    // The shared down-counter only ever holds (largest interval - 1).
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pulse_qualifier.sv
// rtl/pulse_qualifier.sv - synchronizer, run-length glitch filter and one-shot detect strobe
module pulse_qualifier #(
    parameter int MIN_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_pulse,
    output logic det
);

    localparam int RW = $clog2(MIN_WIDTH + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MIN_WIDTH);
    localparam logic [RW-1:0] RUN_LAST = RW'(MIN_WIDTH - 1);

    logic          s1;
    logic          s2;
    logic [RW-1:0] run;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            run <= '0;
            det <= 1'b0;
        end else begin
            s1 <= rx_pulse;
            s2 <= s1;
            if (!s2) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + RW'(1);
            end
            // Fires only on the step into MIN_WIDTH; saturation keeps a held input from re-firing.
            det <= s2 && (run == RUN_LAST);
        end
    end

endmodule

// File: rtl/echo_responder.sv
// rtl/echo_responder.sv - far-end transponder: qualified pulse in, fixed-turnaround reply out
module echo_responder
    import pulse_meter_pkg::*;
#(
    parameter int MIN_WIDTH      = DEF_MIN_WIDTH,
    parameter int DELAY_CYCLES   = DEF_DELAY_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_pulse,
    input  logic             enable,
    output logic             reply_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] missed_count
);

    localparam int TW = timer_width(DELAY_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES);
    // The cycle spent registering det already counts toward the turnaround.
    localparam logic [TW-1:0] DELAY_LOAD   = TW'((DELAY_CYCLES > 1) ? DELAY_CYCLES - 2 : 0);
    localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] HOLDOFF_LOAD = TW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    logic          det;
    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          reply_d;
    logic          accept;

    pulse_qualifier #(
        .MIN_WIDTH(MIN_WIDTH)
    ) u_qualifier (
        .clk     (clk),
        .rst     (rst),
        .rx_pulse(rx_pulse),
        .det     (det)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            reply_pulse  <= 1'b0;
            rx_count     <= '0;
            missed_count <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            reply_pulse <= reply_d;
            if (accept) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (det && (state_q != IDLE) && (missed_count != '1)) begin
                missed_count <= missed_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        reply_d = reply_pulse;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (det && enable) begin
                    accept = 1'b1;
                    if (DELAY_CYCLES == 1) begin
                        state_d = FIRE;
                        timer_d = PULSE_LOAD;
                        reply_d = 1'b1;
                    end else begin
                        state_d = DELAY;
                        timer_d = DELAY_LOAD;
                    end
                end
            end
            DELAY: begin
                if (timer_q == '0) begin
                    state_d = FIRE;
                    timer_d = PULSE_LOAD;
                    reply_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            FIRE: begin
                if (timer_q == '0) begin
                    reply_d = 1'b0;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        timer_d = HOLDOFF_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_echo_responder.sv
// tb/tb_echo_responder.sv - table, directed and randomized checks of echo_responder against a timing model
module tb_echo_responder;

    localparam int MW  = 4;
    localparam int DLY = 100;
    localparam int PW  = 10;
    localparam int HO  = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pulse = 1'b0;
    logic        enable = 1'b1;
    logic        reply_pulse, busy, reply2, busy2;
    logic [15:0] rx_count, missed_count;
    logic [1:0]  rx_count2, missed_count2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    echo_responder #(
        .MIN_WIDTH(MW), .DELAY_CYCLES(DLY), .PULSE_CYCLES(PW), .HOLDOFF_CYCLES(HO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .rx_pulse(rx_pulse), .enable(enable),
        .reply_pulse(reply_pulse), .busy(busy), .rx_count(rx_count), .missed_count(missed_count)
    );

    echo_responder #(
        .MIN_WIDTH(MW), .DELAY_CYCLES(DLY), .PULSE_CYCLES(PW), .HOLDOFF_CYCLES(HO), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .rx_pulse(rx_pulse), .enable(enable),
        .reply_pulse(reply2), .busy(busy2), .rx_count(rx_count2), .missed_count(missed_count2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: raw samples per edge, accepted replies as time windows.
    bit hist[int];
    int last_rst = -100;
    int m_free = 0;
    int m_rise = -1000;
    int m_fall = -1000;
    int m_rx = 0;
    int m_missed = 0;
    bit exp_reply = 1'b0;
    bit exp_busy = 1'b0;

    function automatic bit h(input int t);
        return hist.exists(t) ? hist[t] : 1'b0;
    endfunction

    // Strobe visible after edge t: MW high samples ending two edges earlier, preceded by a low.
    function automatic bit det_after(input int t);
        if (t == last_rst) return 1'b0;
        if (h(t - MW - 2)) return 1'b0;
        for (int i = t - MW - 1; i <= t - 2; i++) begin
            if (!h(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            hist[cyc] = 1'b0;
            hist[cyc - 1] = 1'b0;
            last_rst = cyc;
            m_free = 0;
            m_rise = -1000;
            m_fall = -1000;
            m_rx = 0;
            m_missed = 0;
        end else begin
            hist[cyc] = rx_pulse;
            if (det_after(cyc - 1)) begin
                if (cyc >= m_free) begin
                    if (enable) begin
                        m_rx = m_rx + 1;
                        m_rise = cyc - 1 + DLY;
                        m_fall = m_rise + PW;
                        m_free = cyc + DLY + PW + HO;
                    end
                end else begin
                    m_missed = m_missed + 1;
                end
            end
        end
        exp_reply = (cyc >= m_rise) && (cyc < m_fall);
        exp_busy = (cyc < m_free - 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("reply", int'(reply_pulse), int'(exp_reply));
            check("busy", int'(busy), int'(exp_busy));
            check("rx_count", int'(rx_count), m_rx % 65536);
            check("missed", int'(missed_count), (m_missed > 65535) ? 65535 : m_missed);
            check("reply2", int'(reply2), int'(exp_reply));
            check("busy2", int'(busy2), int'(exp_busy));
            check("rx_count2", int'(rx_count2), m_rx % 4);
            check("missed2", int'(missed_count2), (m_missed > 3) ? 3 : m_missed);
        end
    end

    int rises = 0;
    bit prev_reply = 1'b0;
    always @(negedge clk) begin
        if (reply_pulse && !prev_reply) rises = rises + 1;
        prev_reply = reply_pulse;
    end

    // Rise is returned relative to the edge that first captured the pulse.
    task automatic pulse_measure(input int w, input int drop_en_at, output int rise, output int width);
        int k;
        rise = -1;
        width = 0;
        @(negedge clk);
        rx_pulse = 1'b1;
        k = cyc + 1;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (i == w) rx_pulse = 1'b0;
            if (i == drop_en_at) enable = 1'b0;
            if (reply_pulse) begin
                if (rise < 0) rise = cyc;
                width++;
            end else if (rise >= 0) begin
                break;
            end
        end
        rx_pulse = 1'b0;
        rise = (rise < 0) ? -1 : rise - k;
    endtask

    typedef struct {
        int width;
        int gap;
        bit en;
        int rx;
        int ms;
        int rx2;
        int ms2;
        int rep;
    } row_t;

    row_t tbl[13];

    initial begin
        int rise, width, base, found, w, g;

        tbl[0]  = '{2, 30, 1'b1, 0, 0, 0, 0, 0};
        tbl[1]  = '{3, 30, 1'b1, 0, 0, 0, 0, 0};
        tbl[2]  = '{4, 200, 1'b1, 1, 0, 1, 0, 1};
        tbl[3]  = '{20, 30, 1'b1, 2, 0, 2, 0, 1};
        tbl[4]  = '{6, 83, 1'b1, 2, 1, 2, 1, 2};
        tbl[5]  = '{5, 100, 1'b1, 2, 2, 2, 2, 2};
        tbl[6]  = '{4, 200, 1'b1, 3, 2, 3, 2, 3};
        tbl[7]  = '{8, 200, 1'b0, 3, 2, 3, 2, 3};
        tbl[8]  = '{4, 20, 1'b1, 4, 2, 0, 2, 3};
        tbl[9]  = '{4, 20, 1'b1, 4, 3, 0, 3, 3};
        tbl[10] = '{4, 20, 1'b1, 4, 4, 0, 3, 3};
        tbl[11] = '{4, 200, 1'b1, 4, 5, 0, 3, 4};
        tbl[12] = '{4, 200, 1'b1, 5, 5, 1, 3, 5};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_reply", int'(reply_pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rx", int'(rx_count), 0);
        check("rst_missed", int'(missed_count), 0);

        pulse_measure(20, -1, rise, width);
        check("lat_rise", rise, MW + 1 + DLY);
        check("lat_width", width, PW);
        check("lat_rx", int'(rx_count), 1);
        check("lat_missed", int'(missed_count), 0);
        repeat (60) @(negedge clk);

        pulse_measure(6, 30, rise, width);
        check("endrop_rise", rise, MW + 1 + DLY);
        check("endrop_width", width, PW);
        check("endrop_rx", int'(rx_count), 2);
        repeat (60) @(negedge clk);
        enable = 1'b1;

        @(negedge clk);
        rx_pulse = 1'b1;
        found = 0;
        for (int i = 1; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (i == 6) rx_pulse = 1'b0;
            if (reply_pulse) found = 1;
        end
        rx_pulse = 1'b0;
        check("fire_seen", found, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_reply", int'(reply_pulse), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rx", int'(rx_count), 0);
        check("midrst_missed", int'(missed_count), 0);
        pulse_measure(4, -1, rise, width);
        check("postrst_rise", rise, MW + 1 + DLY);
        check("postrst_width", width, PW);
        check("postrst_rx", int'(rx_count), 1);
        repeat (60) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = rises;
        for (int r = 0; r < 13; r++) begin
            @(negedge clk);
            enable = tbl[r].en;
            rx_pulse = 1'b1;
            repeat (tbl[r].width) @(negedge clk);
            rx_pulse = 1'b0;
            repeat (tbl[r].gap - tbl[r].width) @(negedge clk);
            check($sformatf("tbl%0d_rx", r), int'(rx_count), tbl[r].rx);
            check($sformatf("tbl%0d_missed", r), int'(missed_count), tbl[r].ms);
            check($sformatf("tbl%0d_rx2", r), int'(rx_count2), tbl[r].rx2);
            check($sformatf("tbl%0d_missed2", r), int'(missed_count2), tbl[r].ms2);
            check($sformatf("tbl%0d_replies", r), rises - base, tbl[r].rep);
        end
        enable = 1'b1;

        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(1, 12);
            g = $urandom_range(3, 200);
            @(negedge clk);
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            rx_pulse = 1'b1;
            repeat (w) @(negedge clk);
            rx_pulse = 1'b0;
            repeat (g) @(negedge clk);
        end

        repeat (200) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
